// File: rtl/dbg_cmd_pkg.sv
// Shared defaults and helpers for the debug command bridge.
package dbg_cmd_pkg;

    localparam int DEF_DATA_W      = 38;
    localparam int DEF_IR_W        = 2;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Width needed to count 0..depth entries inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Show-ahead command FIFO: head is presented combinationally whenever
// valid is high; a full FIFO still accepts a push if the head pops in
// the same cycle, otherwise the push is dropped and reported.
module dbg_cmd_fifo
    import dbg_cmd_pkg::*;
#(
    parameter int WIDTH = DEF_IR_W + DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        ready,
    output logic                        valid,
    output logic [WIDTH-1:0]            head,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             full;
    logic             pop;
    logic             wr;

    // Handshake decode; an empty FIFO never pops, so a fresh push is not
    // visible until the following cycle.
    always_comb begin
        valid = (level != '0);
        full  = (level == LVL_W'(DEPTH));
        pop   = valid && ready;
        wr    = push && (!full || pop);
        drop  = push && full && !pop;
        head  = valid ? mem[rptr] : '0;
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr)  wptr <= wptr + PTR_W'(1);
            if (pop) rptr <= rptr + PTR_W'(1);
            case ({wr, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dbg_cmd_bridge.sv
// JTAG update-DR to system-clock command bridge.
// Optional build macro DBG_CMD_PARITY_EN adds an even-parity check on the
// scan word (sr_par input, sticky par_err output).
module dbg_cmd_bridge
    import dbg_cmd_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        upd_tgl,
    input  logic [IR_W-1:0]             ir_in,
    input  logic [DATA_W-1:0]           sr_in,
`ifdef DBG_CMD_PARITY_EN
    input  logic                        sr_par,
    output logic                        par_err,
`endif
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [IR_W-1:0]             cmd_ir,
    output logic [DATA_W-1:0]           cmd_data,
    output logic                        cmd_action,
    output logic                        overflow,
    input  logic                        clr_err,
    output logic [level_w(DEPTH)-1:0]   level
);

    localparam int SUP_W = $clog2(SYNC_STAGES + 2);

    logic [SYNC_STAGES-1:0] sync;
    logic                   last;
    logic                   evt;
    logic [SUP_W-1:0]       sup_cnt;
    logic                   push;
    logic                   drop;
    logic [IR_W+DATA_W-1:0] head;

    // Toggle synchronizer and change detector. The event is registered so
    // ir_in/sr_in are sampled a full cycle after the change is seen; the
    // post-reset window lets last catch up with a toggle held high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= '0;
            last    <= 1'b0;
            evt     <= 1'b0;
            sup_cnt <= SUP_W'(SYNC_STAGES + 1);
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], upd_tgl};
            last <= sync[SYNC_STAGES-1];
            evt  <= (sync[SYNC_STAGES-1] != last) && (sup_cnt == '0);
            if (sup_cnt != '0) begin
                sup_cnt <= sup_cnt - SUP_W'(1);
            end
        end
    end

`ifdef DBG_CMD_PARITY_EN
    logic par_bad;

    // Reject events whose scan word fails even parity.
    always_comb begin
        par_bad = evt && (^{sr_in, sr_par});
        push    = evt && !par_bad;
    end

    // Sticky parity error; a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset)        par_err <= 1'b0;
        else if (par_bad) par_err <= 1'b1;
        else if (clr_err) par_err <= 1'b0;
    end
`else
    // Every detected event is queued.
    always_comb begin
        push = evt;
    end
`endif

    dbg_cmd_fifo #(
        .WIDTH (IR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({ir_in, sr_in}),
        .ready (cmd_ready),
        .valid (cmd_valid),
        .head  (head),
        .level (level),
        .drop  (drop)
    );

    // Split the FIFO head into the command fields.
    always_comb begin
        cmd_ir     = head[IR_W+DATA_W-1 -: IR_W];
        cmd_data   = head[DATA_W-1:0];
        cmd_action = head[DATA_W-1];
    end

    // Sticky overflow; a drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset)        overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_err) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_dbg_cmd_bridge.sv
// Testbench for dbg_cmd_bridge (default parameters). Compile with
// DBG_CMD_PARITY_EN defined to include the parity scenario.
module tb_dbg_cmd_bridge;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd_tgl;
    logic [1:0]  ir_in;
    logic [37:0] sr_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_data;
    logic        cmd_action;
    logic        overflow;
    logic        clr_err;
    logic [2:0]  level;
`ifdef DBG_CMD_PARITY_EN
    logic        sr_par;
    logic        par_err;
    bit          m_perr;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of {ir, sr}, sticky overflow, and a countdown
    // of edges until the pending toggle turns into a push.
    logic [39:0] mq[$];
    bit          m_ovf;
    int          pend;

    always #5 clk = ~clk;

    dbg_cmd_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .upd_tgl    (upd_tgl),
        .ir_in      (ir_in),
        .sr_in      (sr_in),
`ifdef DBG_CMD_PARITY_EN
        .sr_par     (sr_par),
        .par_err    (par_err),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ir     (cmd_ir),
        .cmd_data   (cmd_data),
        .cmd_action (cmd_action),
        .overflow   (overflow),
        .clr_err    (clr_err),
        .level      (level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model across the edge, then compare outputs.
    task automatic step();
        bit          do_pop;
        bit          do_push;
        bit          rst_now;
        bit          clr_now;
        bit          set_ovf;
        int          sz;
        logic [39:0] exp;
        do_pop  = (mq.size() != 0) && cmd_ready;
        rst_now = reset;
        clr_now = clr_err;
        @(posedge clk);
        #1;
        if (rst_now) begin
            mq.delete();
            m_ovf = 0;
            pend  = 0;
`ifdef DBG_CMD_PARITY_EN
            m_perr = 0;
`endif
        end else begin
            do_push = (pend == 1);
            if (pend > 0) pend--;
            sz = mq.size();
            set_ovf = 0;
            if (do_pop) void'(mq.pop_front());
`ifdef DBG_CMD_PARITY_EN
            if (do_push && (^{sr_in, sr_par})) begin
                do_push = 0;
                m_perr  = 1;
            end else if (clr_now) begin
                m_perr = 0;
            end
`endif
            if (do_push) begin
                if (sz < DEPTH || do_pop) mq.push_back({ir_in, sr_in});
                else set_ovf = 1;
            end
            m_ovf = set_ovf ? 1'b1 : (clr_now ? 1'b0 : m_ovf);
        end
        exp = (mq.size() != 0) ? mq[0] : 40'h0;
        chk("valid", cmd_valid, mq.size() != 0);
        chk("level", level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("ir", cmd_ir, exp[39:38]);
        chk("data", cmd_data, exp[37:0]);
        chk("action", cmd_action, exp[37]);
`ifdef DBG_CMD_PARITY_EN
        chk("par_err", par_err, m_perr);
`endif
    endtask

    task automatic toggle(input logic [1:0] ir, input logic [37:0] sr);
        upd_tgl = ~upd_tgl;
        ir_in   = ir;
        sr_in   = sr;
`ifdef DBG_CMD_PARITY_EN
        sr_par  = ^sr;
`endif
        pend    = 4;
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            toggle(2'(i), 38'(base + i));
            repeat (5) step();
        end
    endtask

    task automatic drain();
        cmd_ready = 1'b1;
        repeat (DEPTH + 1) step();
        cmd_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        reset = 1'b1; upd_tgl = 1'b0; cmd_ready = 1'b0; clr_err = 1'b0;
        ir_in = '0; sr_in = '0; pend = 0; m_ovf = 0;
`ifdef DBG_CMD_PARITY_EN
        sr_par = 1'b0; m_perr = 0;
`endif
        step(); step();
        chk("rst_valid", cmd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_data", cmd_data, 0);

        // Toggle held high through reset release: nothing is queued.
        upd_tgl = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("no_spurious", cmd_valid, 0);
        end

        // Single command: valid appears on the fourth edge after the toggle.
        toggle(2'b01, 38'h20_0000_0001);
        step(); chk("lat_e1", cmd_valid, 0);
        step(); chk("lat_e2", cmd_valid, 0);
        step(); chk("lat_e3", cmd_valid, 0);
        step();
        chk("lat_valid", cmd_valid, 1);
        chk("lat_action", cmd_action, 1);
        chk("lat_ir", cmd_ir, 1);
        chk("lat_level", level, 1);
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        chk("pop_one", level, 0);

        // Five toggles without ready: four kept in order, one dropped.
        fill(5, 1);
        chk("full_level", level, 4);
        chk("full_ovf", overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("pop_order", cmd_data, 64'(i));
            cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        end
        chk("drained", level, 0);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Push into a full FIFO alongside a pop is accepted.
        fill(4, 10);
        toggle(2'b10, 38'd14);
        step(); step(); step();
        cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
        chk("fullpop_ovf", overflow, 0);
        chk("fullpop_level", level, 4);
        chk("fullpop_head", cmd_data, 11);
        drain();

        // Clear coincident with an overflowing push leaves the flag set.
        fill(4, 20);
        toggle(2'b11, 38'd24);
        step(); step(); step();
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("clr_vs_set", overflow, 1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("clr_alone", overflow, 0);
        drain();

`ifdef DBG_CMD_PARITY_EN
        toggle(2'b00, 38'd1);
        sr_par = 1'b0;
        repeat (5) step();
        chk("par_drop_level", level, 0);
        chk("par_err_set", par_err, 1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        toggle(2'b00, 38'd1);
        sr_par = 1'b1;
        repeat (5) step();
        chk("par_ok_level", level, 1);
        drain();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step();
            cmd_ready = ($urandom % 4 == 0);
            clr_err   = ($urandom % 16 == 0);
            if (pend == 0 && ($urandom % 3 == 0)) begin
                r = {$urandom, $urandom};
                toggle(2'(r[39:38]), r[37:0]);
`ifdef DBG_CMD_PARITY_EN
                if ($urandom % 8 == 0) sr_par = ~sr_par;
`endif
            end
        end
        cmd_ready = 1'b0; clr_err = 1'b0;
        repeat (6) step();

        // Reset mid-operation discards queued commands.
        drain();
        fill(2, 40);
        chk("pre_rst_level", level, 2);
        reset = 1'b1; cmd_ready = 1'b1; step();
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", cmd_valid, 0);
        reset = 1'b0; cmd_ready = 1'b0;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
